// File: rtl/keypad_pkg.sv
// keypad_pkg: shared scan-state type, one-hot row/column constants and key codes for the keypad path
// Items: scan_state_t, ROW0..ROW3, COL0..COL3, named key codes, is_onehot4, next_col
package keypad_pkg;

    typedef enum logic [1:0] {SCAN, DEB_PRESS, PRESSED, WAIT_REL} scan_state_t;

    // Index 0 sits in the MSB on both row and column buses.
    localparam logic [3:0] ROW0 = 4'b1000;
    localparam logic [3:0] ROW1 = 4'b0100;
    localparam logic [3:0] ROW2 = 4'b0010;
    localparam logic [3:0] ROW3 = 4'b0001;
    localparam logic [3:0] COL0 = 4'b1000;
    localparam logic [3:0] COL1 = 4'b0100;
    localparam logic [3:0] COL2 = 4'b0010;
    localparam logic [3:0] COL3 = 4'b0001;

    localparam logic [7:0] KEY_7         = {ROW2, COL0};
    localparam logic [7:0] KEY_9         = {ROW2, COL2};
    localparam logic [7:0] SUBMIT_LETTER = {ROW3, COL0};
    localparam logic [7:0] CLEAR         = {ROW3, COL1};
    localparam logic [7:0] SUBMIT_WORD   = {ROW3, COL2};
    localparam logic [7:0] GAME_END      = {ROW2, COL3};

    function automatic logic is_onehot4(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

    // C0 -> C1 -> C2 -> C3 -> C0 is a rotate right with index 0 at the MSB.
    function automatic logic [3:0] next_col(input logic [3:0] c);
        return {c[0], c[3:1]};
    endfunction

endpackage

// File: rtl/sync2.sv
// sync2: generic N-bit two-flop synchroniser with asynchronous active-low reset to zero
// Ports: clk, nRst, d[N-1:0] asynchronous input, q[N-1:0] synchronised output
module sync2 #(
    parameter int N = 1
) (
    input  logic         clk,
    input  logic         nRst,
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);

    logic [N-1:0] meta;

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 keypad column scanner with press/release debounce and one strobe per press
// Ports: clk, nRst (async, active-low), row_in[3:0] raw rows, col_drive[3:0] one-hot column drive,
//        strobe single-cycle press pulse, cur_key[7:0] {row,col} one-hot code, key_held press-to-release flag
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SETTLE_CYCLES   = 16,
    parameter int DEBOUNCE_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       nRst,
    input  logic [3:0] row_in,
    output logic [3:0] col_drive,
    output logic       strobe,
    output logic [7:0] cur_key,
    output logic       key_held
);

    localparam int SW = $clog2(SETTLE_CYCLES);
    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [SW-1:0] DWELL_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_CYCLES - 1);

    scan_state_t   state, state_n;
    logic [3:0]    row_s, row_cap, row_cap_n, col_n;
    logic [SW-1:0] dwell, dwell_n;
    logic [DW-1:0] cnt, cnt_n;
    logic [7:0]    cur_key_n;
    logic          strobe_n, key_held_n;
    logic          dwell_end, row_one, row_match, deb_done, rel_done;

    sync2 #(.N(4)) u_sync (
        .clk  (clk),
        .nRst (nRst),
        .d    (row_in),
        .q    (row_s)
    );

    assign dwell_end = dwell == DWELL_LAST;
    assign row_one   = is_onehot4(row_s);
    assign row_match = row_s == row_cap;
    assign deb_done  = row_match && cnt == DEB_LAST;
    assign rel_done  = row_s == 4'd0 && cnt == DEB_LAST;

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state     <= SCAN;
            col_drive <= COL0;
            dwell     <= '0;
            cnt       <= '0;
            row_cap   <= '0;
            strobe    <= 1'b0;
            cur_key   <= 8'h00;
            key_held  <= 1'b0;
        end else begin
            state     <= state_n;
            col_drive <= col_n;
            dwell     <= dwell_n;
            cnt       <= cnt_n;
            row_cap   <= row_cap_n;
            strobe    <= strobe_n;
            cur_key   <= cur_key_n;
            key_held  <= key_held_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            SCAN:      state_n = (dwell_end && row_one) ? DEB_PRESS : SCAN;
            DEB_PRESS: state_n = !row_match ? SCAN : deb_done ? PRESSED : DEB_PRESS;
            PRESSED:   state_n = WAIT_REL;
            WAIT_REL:  state_n = rel_done ? SCAN : WAIT_REL;
            default:   state_n = SCAN;
        endcase
    end

    // strobe/cur_key/key_held are loaded on the edge that enters PRESSED so the
    // key code is already valid during the strobe cycle.
    always_comb begin
        col_n      = col_drive;
        dwell_n    = '0;
        cnt_n      = '0;
        row_cap_n  = row_cap;
        strobe_n   = 1'b0;
        cur_key_n  = cur_key;
        key_held_n = key_held;
        case (state)
            SCAN: begin
                if (!dwell_end)
                    dwell_n = dwell + 1'b1;
                else if (row_one)
                    row_cap_n = row_s;
                else
                    col_n = next_col(col_drive);
            end
            DEB_PRESS: begin
                if (row_match) begin
                    cnt_n = deb_done ? cnt : cnt + 1'b1;
                    if (deb_done) begin
                        strobe_n   = 1'b1;
                        cur_key_n  = {row_cap, col_drive};
                        key_held_n = 1'b1;
                    end
                end
            end
            WAIT_REL: begin
                if (row_s == 4'd0) begin
                    cnt_n = rel_done ? cnt : cnt + 1'b1;
                    if (rel_done) begin
                        key_held_n = 1'b0;
                        col_n      = next_col(col_drive);
                    end
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed scoreboard bench for keypad_scanner with a behavioural 4x4 key matrix
module tb_keypad_scanner;
    import keypad_pkg::*;

    localparam int S = 4;
    localparam int D = 8;
    localparam int PRESS_LAT = S + D;
    localparam int REL_LAT   = 2 + D;
    localparam int WORST_LAT = 4 * S + 2 + D + 1;

    logic       clk = 1'b0;
    logic       nRst;
    logic [3:0] row_in;
    logic [3:0] col_drive;
    logic       strobe;
    logic [7:0] cur_key;
    logic       key_held;
    logic [15:0] keys;

    logic [7:0] exp_q[$];
    int n_vec = 0;
    int n_err = 0;
    logic prev_strobe = 1'b0;

    keypad_scanner #(.SETTLE_CYCLES(S), .DEBOUNCE_CYCLES(D)) dut (
        .clk       (clk),
        .nRst      (nRst),
        .row_in    (row_in),
        .col_drive (col_drive),
        .strobe    (strobe),
        .cur_key   (cur_key),
        .key_held  (key_held)
    );

    always #5 clk = ~clk;

    // keys[r*4+c] closes the switch between row r and column c.
    always_comb begin
        row_in = 4'd0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && col_drive[3-c]) row_in[3-r] = 1'b1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [7:0] e;
        if (strobe) begin
            if (prev_strobe) check("strobe_single_cycle", 32'(prev_strobe), 32'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_strobe", {24'd0, cur_key}, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("strobe_key", {24'd0, cur_key}, {24'd0, e});
                check("held_at_strobe", 32'(key_held), 32'd1);
            end
        end
        prev_strobe = strobe;
    end

    task automatic wait_strobe(input int limit, output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!strobe && cyc < limit);
        if (!strobe) check("strobe_timeout", 32'(strobe), 32'd1);
    endtask

    task automatic wait_release(input int limit, output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (key_held && cyc < limit);
        if (key_held) check("release_timeout", 32'(key_held), 32'd0);
    endtask

    task automatic align_c0();
        int n;
        n = 0;
        while (col_drive != COL3 && n < 40) begin @(negedge clk); n++; end
        while (col_drive != COL0 && n < 40) begin @(negedge clk); n++; end
        if (col_drive != COL0) check("align_timeout", {28'd0, col_drive}, {28'd0, COL0});
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_col"},     {28'd0, col_drive}, {28'd0, COL0});
        check({tag, "_strobe"},  32'(strobe), 32'd0);
        check({tag, "_cur_key"}, {24'd0, cur_key}, 32'd0);
        check({tag, "_held"},    32'(key_held), 32'd0);
    endtask

    initial begin
        int cyc;
        int ok;
        nRst = 1'b0;
        keys = 16'd0;
        repeat (3) @(negedge clk);
        check_reset("reset");
        nRst = 1'b1;
        repeat (200) @(negedge clk);
        check("idle_held", 32'(key_held), 32'd0);

        // Clean press R2C0, exact press and release latency
        align_c0();
        keys[8] = 1'b1;
        exp_q.push_back(KEY_7);
        wait_strobe(100, cyc);
        check("t2_press_latency", cyc, PRESS_LAT);
        repeat (100) @(negedge clk);
        check("t2_held_while_pressed", 32'(key_held), 32'd1);
        keys[8] = 1'b0;
        wait_release(50, cyc);
        check("t2_release_latency", cyc, REL_LAT);
        check("t2_resume_col", {28'd0, col_drive}, {28'd0, COL1});
        check("t2_cur_key_kept", {24'd0, cur_key}, {24'd0, KEY_7});

        // Bouncing R3C0, then stable
        repeat (10) @(negedge clk);
        for (int i = 0; i < 14; i++) begin
            keys[12] = ~keys[12];
            repeat (3) @(negedge clk);
        end
        keys[12] = 1'b1;
        exp_q.push_back(SUBMIT_LETTER);
        wait_strobe(100, cyc);
        ok = (cyc <= WORST_LAT) ? 1 : 0;
        check("t3_latency_bound", ok, 1);
        keys[12] = 1'b0;
        wait_release(50, cyc);
        check("t3_release_latency", cyc, REL_LAT);

        // Two rows on C2: ghosted until R1 released
        repeat (10) @(negedge clk);
        keys[2] = 1'b1;
        keys[6] = 1'b1;
        repeat (60) @(negedge clk);
        check("t4_multi_not_held", 32'(key_held), 32'd0);
        keys[6] = 1'b0;
        exp_q.push_back(8'b1000_0010);
        wait_strobe(100, cyc);
        ok = (cyc <= WORST_LAT) ? 1 : 0;
        check("t4_latency_bound", ok, 1);
        keys[2] = 1'b0;
        wait_release(50, cyc);

        // R1C3 with glitchy release, then a second clean press
        repeat (10) @(negedge clk);
        keys[7] = 1'b1;
        exp_q.push_back(8'b0100_0001);
        wait_strobe(100, cyc);
        repeat (20) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            keys[7] = 1'b0;
            repeat (4) @(negedge clk);
            keys[7] = 1'b1;
            @(negedge clk);
        end
        check("t5_held_through_glitches", 32'(key_held), 32'd1);
        keys[7] = 1'b0;
        wait_release(50, cyc);
        check("t5_release_latency", cyc, REL_LAT);
        repeat (20) @(negedge clk);
        keys[7] = 1'b1;
        exp_q.push_back(8'b0100_0001);
        wait_strobe(100, cyc);
        keys[7] = 1'b0;
        wait_release(50, cyc);

        // Reset while DEB_PRESS count is 5
        align_c0();
        keys[8] = 1'b1;
        repeat (S + 5) @(negedge clk);
        nRst = 1'b0;
        #1;
        check_reset("t6_reset");
        repeat (3) @(negedge clk);
        nRst = 1'b1;
        exp_q.push_back(KEY_7);
        wait_strobe(100, cyc);
        check("t6_fresh_latency", cyc, PRESS_LAT);
        keys[8] = 1'b0;
        wait_release(50, cyc);

        repeat (20) @(negedge clk);
        check("queue_drained", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule
